// File: rtl/serial_nibble_adder_pkg.sv
// Shared definitions for the nibble-serial wide adder: FSM encoding and nibble width.
package serial_nibble_adder_pkg;
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/serial_nibble_adder_adder4.sv
// Combinational 4-bit adder with carry in and carry out. It is reused as the per-nibble slice.
module Adder_4_bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout
);
  assign {Cout, S} = {1'b0, A} + {1'b0, B} + {4'b0, Cin};
endmodule

// File: rtl/serial_nibble_adder.sv
// Wide adder that reuses one 4-bit adder. It takes one nibble per clock, LS nibble first,
// and ripples the carry through a register. Operands arrive and the result leaves over valid/ready.
module serial_nibble_adder
  import serial_nibble_adder_pkg::*;
#(
  parameter int NIBBLES = 4,
  localparam int W = NIBBLE_W * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] S,
  output logic         Cout,
  output logic         busy
);
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  state_t              state;
  logic [W-1:0]        a_reg, b_reg, acc;
  logic                carry_reg;
  logic [CW-1:0]       cnt;
  logic [NIBBLE_W-1:0] nib_s;
  logic                nib_cout;
  logic [W-1:0]        acc_nxt;

  Adder_4_bit u_add (
    .A    (a_reg[NIBBLE_W-1:0]),
    .B    (b_reg[NIBBLE_W-1:0]),
    .Cin  (carry_reg),
    .S    (nib_s),
    .Cout (nib_cout)
  );

  // The new sum nibble enters at the MS end. After NIBBLES shifts the result is aligned.
  assign acc_nxt  = W'({nib_s, acc} >> NIBBLE_W);
  assign in_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      carry_reg <= 1'b0;
      cnt       <= '0;
      S         <= '0;
      Cout      <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_reg     <= A;
          b_reg     <= B;
          carry_reg <= Cin;
          cnt       <= '0;
          busy      <= 1'b1;
          state     <= ADD;
        end
        ADD: begin
          acc       <= acc_nxt;
          a_reg     <= a_reg >> NIBBLE_W;
          b_reg     <= b_reg >> NIBBLE_W;
          carry_reg <= nib_cout;
          cnt       <= cnt + 1'b1;
          // S and Cout are only updated here, so they hold the previous result during ADD.
          if (cnt == LAST) begin
            S         <= acc_nxt;
            Cout      <= nib_cout;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
